// File: rtl/me_pixel_feeder.sv
// ME pixel feeder: buffers current/reference word streams and serves
// them to the ME core one word per read request, framed by en_o.
module me_pixel_feeder #(
   parameter int CUR_WORDS = 16,
   parameter int REF_WORDS = 64,
   parameter int CUR_DEPTH = 32,
   parameter int REF_DEPTH = 128
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cur_s_valid,
   output logic        cur_s_ready,
   input  logic [31:0] cur_s_data,
   input  logic        ref_s_valid,
   output logic        ref_s_ready,
   input  logic [63:0] ref_s_data,
   output logic        en_o,
   input  logic        cur_read_en,
   input  logic        ref_read_en,
   output logic [31:0] cur_out,
   output logic [63:0] ref_out,
   output logic        block_done,
   output logic        underflow
);

   localparam int CUR_AW = (CUR_DEPTH > 1) ? $clog2(CUR_DEPTH) : 1;
   localparam int REF_AW = (REF_DEPTH > 1) ? $clog2(REF_DEPTH) : 1;
   localparam int CUR_CW = $clog2(CUR_DEPTH + 1);
   localparam int REF_CW = $clog2(REF_DEPTH + 1);
   localparam int CUR_SW = $clog2(CUR_WORDS + 1);
   localparam int REF_SW = $clog2(REF_WORDS + 1);

   localparam logic [CUR_CW-1:0] CUR_FULL = CUR_CW'(CUR_DEPTH);
   localparam logic [REF_CW-1:0] REF_FULL = REF_CW'(REF_DEPTH);
   localparam logic [CUR_CW-1:0] CUR_BLK  = CUR_CW'(CUR_WORDS);
   localparam logic [REF_CW-1:0] REF_BLK  = REF_CW'(REF_WORDS);
   localparam logic [CUR_SW-1:0] CUR_TOT  = CUR_SW'(CUR_WORDS);
   localparam logic [REF_SW-1:0] REF_TOT  = REF_SW'(REF_WORDS);
   localparam logic [CUR_AW-1:0] CUR_LAST = CUR_AW'(CUR_DEPTH - 1);
   localparam logic [REF_AW-1:0] REF_LAST = REF_AW'(REF_DEPTH - 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACTIVE = 1'b1;

   logic [31:0]       cur_mem_q [CUR_DEPTH];
   logic [63:0]       ref_mem_q [REF_DEPTH];

   logic [CUR_AW-1:0] cur_wr_q, cur_wr_d;
   logic [CUR_AW-1:0] cur_rd_q, cur_rd_d;
   logic [CUR_CW-1:0] cur_cnt_q, cur_cnt_d;
   logic [REF_AW-1:0] ref_wr_q, ref_wr_d;
   logic [REF_AW-1:0] ref_rd_q, ref_rd_d;
   logic [REF_CW-1:0] ref_cnt_q, ref_cnt_d;

   logic [31:0]       cur_out_q, cur_out_d;
   logic [63:0]       ref_out_q, ref_out_d;
   logic              und_q, und_d;
   logic              done_q, done_d;

   logic [0:0]        state_q, state_d;
   logic [CUR_SW-1:0] cur_srv_q, cur_srv_d, cur_srv_nx;
   logic [REF_SW-1:0] ref_srv_q, ref_srv_d, ref_srv_nx;

   logic cur_push, cur_pop, cur_empty;
   logic ref_push, ref_pop, ref_empty;

   // Handshake and pop qualification from registered counts
   always_comb begin
      cur_empty   = (cur_cnt_q == '0);
      ref_empty   = (ref_cnt_q == '0);
      cur_s_ready = (cur_cnt_q < CUR_FULL);
      ref_s_ready = (ref_cnt_q < REF_FULL);
      cur_push    = cur_s_valid & cur_s_ready;
      ref_push    = ref_s_valid & ref_s_ready;
      cur_pop     = cur_read_en & ~cur_empty;
      ref_pop     = ref_read_en & ~ref_empty;
   end

   // Current FIFO pointer and occupancy next-state
   always_comb begin
      cur_wr_d  = cur_wr_q;
      cur_rd_d  = cur_rd_q;
      cur_cnt_d = cur_cnt_q;
      if (cur_push) begin
         cur_wr_d = (cur_wr_q == CUR_LAST) ? '0 : cur_wr_q + CUR_AW'(1);
      end
      if (cur_pop) begin
         cur_rd_d = (cur_rd_q == CUR_LAST) ? '0 : cur_rd_q + CUR_AW'(1);
      end
      unique case ({cur_push, cur_pop})
         2'b10:   cur_cnt_d = cur_cnt_q + CUR_CW'(1);
         2'b01:   cur_cnt_d = cur_cnt_q - CUR_CW'(1);
         default: cur_cnt_d = cur_cnt_q;
      endcase
   end

   // Reference FIFO pointer and occupancy next-state
   always_comb begin
      ref_wr_d  = ref_wr_q;
      ref_rd_d  = ref_rd_q;
      ref_cnt_d = ref_cnt_q;
      if (ref_push) begin
         ref_wr_d = (ref_wr_q == REF_LAST) ? '0 : ref_wr_q + REF_AW'(1);
      end
      if (ref_pop) begin
         ref_rd_d = (ref_rd_q == REF_LAST) ? '0 : ref_rd_q + REF_AW'(1);
      end
      unique case ({ref_push, ref_pop})
         2'b10:   ref_cnt_d = ref_cnt_q + REF_CW'(1);
         2'b01:   ref_cnt_d = ref_cnt_q - REF_CW'(1);
         default: ref_cnt_d = ref_cnt_q;
      endcase
   end

   // Output words hold until the next successful pop; empty reads stick
   always_comb begin
      cur_out_d = cur_out_q;
      ref_out_d = ref_out_q;
      und_d     = und_q;
      if (cur_pop) cur_out_d = cur_mem_q[cur_rd_q];
      if (ref_pop) ref_out_d = ref_mem_q[ref_rd_q];
      if ((cur_read_en & cur_empty) | (ref_read_en & ref_empty)) begin
         und_d = 1'b1;
      end
   end

   // Served counters saturate at the per-block totals
   always_comb begin
      cur_srv_nx = cur_srv_q;
      ref_srv_nx = ref_srv_q;
      if (cur_pop && (cur_srv_q != CUR_TOT)) begin
         cur_srv_nx = cur_srv_q + CUR_SW'(1);
      end
      if (ref_pop && (ref_srv_q != REF_TOT)) begin
         ref_srv_nx = ref_srv_q + REF_SW'(1);
      end
   end

   // Block framing FSM: wait for a full block, then count deliveries
   always_comb begin
      state_d   = state_q;
      cur_srv_d = cur_srv_q;
      ref_srv_d = ref_srv_q;
      done_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if ((cur_cnt_q >= CUR_BLK) && (ref_cnt_q >= REF_BLK)) begin
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            cur_srv_d = cur_srv_nx;
            ref_srv_d = ref_srv_nx;
            if ((cur_srv_nx == CUR_TOT) && (ref_srv_nx == REF_TOT)) begin
               done_d    = 1'b1;
               cur_srv_d = '0;
               ref_srv_d = '0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Storage arrays need no reset; occupancy counts define validity
   always_ff @(posedge clk) begin
      if (cur_push) cur_mem_q[cur_wr_q] <= cur_s_data;
      if (ref_push) ref_mem_q[ref_wr_q] <= ref_s_data;
   end

   // FIFO control state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_wr_q  <= '0;
         cur_rd_q  <= '0;
         cur_cnt_q <= '0;
         ref_wr_q  <= '0;
         ref_rd_q  <= '0;
         ref_cnt_q <= '0;
      end else begin
         cur_wr_q  <= cur_wr_d;
         cur_rd_q  <= cur_rd_d;
         cur_cnt_q <= cur_cnt_d;
         ref_wr_q  <= ref_wr_d;
         ref_rd_q  <= ref_rd_d;
         ref_cnt_q <= ref_cnt_d;
      end
   end

   // Output registers, sticky underflow and FSM state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur_out_q <= '0;
         ref_out_q <= '0;
         und_q     <= 1'b0;
         done_q    <= 1'b0;
         state_q   <= S_IDLE;
         cur_srv_q <= '0;
         ref_srv_q <= '0;
      end else begin
         cur_out_q <= cur_out_d;
         ref_out_q <= ref_out_d;
         und_q     <= und_d;
         done_q    <= done_d;
         state_q   <= state_d;
         cur_srv_q <= cur_srv_d;
         ref_srv_q <= ref_srv_d;
      end
   end

   assign en_o       = (state_q == S_ACTIVE);
   assign cur_out    = cur_out_q;
   assign ref_out    = ref_out_q;
   assign block_done = done_q;
   assign underflow  = und_q;

endmodule

// File: tb/tb_me_pixel_feeder.sv
// Directed bench for me_pixel_feeder: block delivery, full/empty
// behaviour, back-to-back blocks across pointer wrap, mid-block reset.
module tb_me_pixel_feeder;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cur_s_valid, cur_s_ready;
   logic [31:0] cur_s_data;
   logic        ref_s_valid, ref_s_ready;
   logic [63:0] ref_s_data;
   logic        en_o;
   logic        cur_read_en, ref_read_en;
   logic [31:0] cur_out;
   logic [63:0] ref_out;
   logic        block_done, underflow;

   int tests = 0;
   int fails = 0;

   me_pixel_feeder dut (
      .clk(clk), .rst(rst),
      .cur_s_valid(cur_s_valid), .cur_s_ready(cur_s_ready),
      .cur_s_data(cur_s_data),
      .ref_s_valid(ref_s_valid), .ref_s_ready(ref_s_ready),
      .ref_s_data(ref_s_data),
      .en_o(en_o),
      .cur_read_en(cur_read_en), .ref_read_en(ref_read_en),
      .cur_out(cur_out), .ref_out(ref_out),
      .block_done(block_done), .underflow(underflow)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cur_s_valid = 1'b0;
      ref_s_valid = 1'b0;
      cur_s_data  = '0;
      ref_s_data  = '0;
      cur_read_en = 1'b0;
      ref_read_en = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cur_s_valid = 1'($urandom);
         ref_s_valid = 1'($urandom);
         cur_s_data  = $urandom;
         ref_s_data  = {$urandom, $urandom};
         cur_read_en = 1'($urandom);
         ref_read_en = 1'($urandom);
         tick();
      end
      tests++;
      if ({en_o, block_done, underflow, cur_out, ref_out} !== '0) begin
         fails++;
         $display("FAIL reset_outputs: en=%b bd=%b uf=%b cur=%h ref=%h want all 0",
                  en_o, block_done, underflow, cur_out, ref_out);
      end
      tests++;
      if ({cur_s_ready, ref_s_ready} !== 2'b11) begin
         fails++;
         $display("FAIL reset_ready: got %b%b want 11", cur_s_ready, ref_s_ready);
      end
      idle();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_block();
      for (int i = 0; i < 64; i++) begin
         cur_s_valid = (i < 16);
         cur_s_data  = 32'(i);
         ref_s_valid = 1'b1;
         ref_s_data  = {2{32'(i)}};
         tick();
      end
      idle();
      tests++;
      if (en_o !== 1'b0) begin
         fails++;
         $display("FAIL blk_en_early: got %b want 0", en_o);
      end
      tick();
      tests++;
      if (en_o !== 1'b1) begin
         fails++;
         $display("FAIL blk_en_rise: got %b want 1", en_o);
      end
      for (int k = 0; k < 64; k++) begin
         cur_read_en = (k < 16);
         ref_read_en = 1'b1;
         tick();
         tests++;
         if (cur_out !== 32'(k < 16 ? k : 15)) begin
            fails++;
            $display("FAIL blk_cur[%0d]: got %h want %h", k, cur_out, 32'(k < 16 ? k : 15));
         end
         tests++;
         if (ref_out !== {2{32'(k)}}) begin
            fails++;
            $display("FAIL blk_ref[%0d]: got %h want %h", k, ref_out, {2{32'(k)}});
         end
         tests++;
         if ({block_done, en_o} !== ((k == 63) ? 2'b10 : 2'b01)) begin
            fails++;
            $display("FAIL blk_frame[%0d]: got bd,en=%b%b want %b", k, block_done, en_o,
                     (k == 63) ? 2'b10 : 2'b01);
         end
      end
      idle();
      tick();
      tests++;
      if ({block_done, en_o} !== 2'b00) begin
         fails++;
         $display("FAIL blk_after: got bd,en=%b%b want 00", block_done, en_o);
      end
   endtask

   task automatic test_full();
      logic [31:0] exp;
      for (int i = 0; i < 32; i++) begin
         cur_s_valid = 1'b1;
         cur_s_data  = 32'(100 + i);
         tick();
      end
      tests++;
      if (cur_s_ready !== 1'b0) begin
         fails++;
         $display("FAIL full_ready: got %b want 0", cur_s_ready);
      end
      cur_s_data = 32'd999;
      tick();
      tests++;
      if (cur_s_ready !== 1'b0) begin
         fails++;
         $display("FAIL full_ignore: got %b want 0", cur_s_ready);
      end
      cur_s_data  = 32'd200;
      cur_read_en = 1'b1;
      tick();
      tests++;
      if ({cur_out, cur_s_ready} !== {32'd100, 1'b1}) begin
         fails++;
         $display("FAIL full_pop: got %h/%b want 100/1", cur_out, cur_s_ready);
      end
      tick();
      tests++;
      if ({cur_out, cur_s_ready} !== {32'd101, 1'b1}) begin
         fails++;
         $display("FAIL full_pushpop: got %h/%b want 101/1", cur_out, cur_s_ready);
      end
      cur_s_data  = 32'd201;
      cur_read_en = 1'b0;
      tick();
      tests++;
      if (cur_s_ready !== 1'b0) begin
         fails++;
         $display("FAIL full_refill: got %b want 0", cur_s_ready);
      end
      idle();
      for (int i = 0; i < 32; i++) begin
         cur_read_en = 1'b1;
         exp = (i < 30) ? 32'(102 + i) : 32'(200 + i - 30);
         tick();
         tests++;
         if (cur_out !== exp) begin
            fails++;
            $display("FAIL full_drain[%0d]: got %h want %h", i, cur_out, exp);
         end
      end
      idle();
      tests++;
      if (underflow !== 1'b0) begin
         fails++;
         $display("FAIL full_no_uf: got %b want 0", underflow);
      end
   endtask

   task automatic test_underflow();
      ref_read_en = 1'b1;
      tick();
      idle();
      tests++;
      if ({underflow, ref_out} !== {1'b1, {2{32'd63}}}) begin
         fails++;
         $display("FAIL uf_set: got %b/%h want 1/%h", underflow, ref_out, {2{32'd63}});
      end
      repeat (3) tick();
      tests++;
      if (underflow !== 1'b1) begin
         fails++;
         $display("FAIL uf_sticky: got %b want 1", underflow);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (underflow !== 1'b0) begin
         fails++;
         $display("FAIL uf_clear: got %b want 0", underflow);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic read_block(input logic [31:0] cb, input logic [31:0] rb,
                             input bool_push, input logic [31:0] pcb,
                             input logic [31:0] prb, input string nm);
      for (int k = 0; k < 64; k++) begin
         cur_read_en = (k < 16);
         ref_read_en = 1'b1;
         cur_s_valid = bool_push && (k < 16);
         cur_s_data  = pcb + 32'(k);
         ref_s_valid = bool_push;
         ref_s_data  = {2{prb + 32'(k)}};
         tick();
         if (k < 16) begin
            tests++;
            if (cur_out !== cb + 32'(k)) begin
               fails++;
               $display("FAIL %s_cur[%0d]: got %h want %h", nm, k, cur_out, cb + 32'(k));
            end
         end
         tests++;
         if (ref_out !== {2{rb + 32'(k)}}) begin
            fails++;
            $display("FAIL %s_ref[%0d]: got %h want %h", nm, k, ref_out, {2{rb + 32'(k)}});
         end
         tests++;
         if ({block_done, en_o} !== ((k == 63) ? 2'b10 : 2'b01)) begin
            fails++;
            $display("FAIL %s_frame[%0d]: got bd,en=%b%b want %b", nm, k, block_done, en_o,
                     (k == 63) ? 2'b10 : 2'b01);
         end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 128; i++) begin
         cur_s_valid = (i < 32);
         cur_s_data  = (i < 16) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 16);
         ref_s_valid = 1'b1;
         ref_s_data  = (i < 64) ? {2{32'h1000 + 32'(i)}} : {2{32'h2000 + 32'(i - 64)}};
         tick();
      end
      idle();
      tests++;
      if ({cur_s_ready, ref_s_ready, en_o} !== 3'b001) begin
         fails++;
         $display("FAIL b2b_prefill: got rdy,rdy,en=%b%b%b want 001",
                  cur_s_ready, ref_s_ready, en_o);
      end
      read_block(32'h100, 32'h1000, 1'b0, 32'h0, 32'h0, "b1");
      tick();
      tests++;
      if ({block_done, en_o} !== 2'b01) begin
         fails++;
         $display("FAIL b2b_gap1: got bd,en=%b%b want 01", block_done, en_o);
      end
      read_block(32'h200, 32'h2000, 1'b1, 32'h300, 32'h3000, "b2");
      tick();
      tests++;
      if ({block_done, en_o} !== 2'b01) begin
         fails++;
         $display("FAIL b2b_gap2: got bd,en=%b%b want 01", block_done, en_o);
      end
      read_block(32'h300, 32'h3000, 1'b0, 32'h0, 32'h0, "b3");
      tick();
      tests++;
      if ({block_done, en_o, underflow} !== 3'b000) begin
         fails++;
         $display("FAIL b2b_end: got bd,en,uf=%b%b%b want 000", block_done, en_o, underflow);
      end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 64; i++) begin
         cur_s_valid = (i < 16);
         cur_s_data  = 32'h500 + 32'(i);
         ref_s_valid = 1'b1;
         ref_s_data  = {2{32'h5000 + 32'(i)}};
         tick();
      end
      idle();
      tick();
      for (int k = 0; k < 8; k++) begin
         cur_read_en = 1'b1;
         ref_read_en = 1'b1;
         tick();
      end
      idle();
      tests++;
      if ({en_o, cur_out} !== {1'b1, 32'h507}) begin
         fails++;
         $display("FAIL mid_pre: got en=%b cur=%h want 1/507", en_o, cur_out);
      end
      #2;
      rst = 1'b0;
      #1;
      tests++;
      if ({en_o, block_done, underflow, cur_out, ref_out, cur_s_ready, ref_s_ready}
          !== {3'b000, 96'h0, 2'b11}) begin
         fails++;
         $display("FAIL mid_reset: en=%b bd=%b uf=%b cur=%h ref=%h rdy=%b%b want zeros/11",
                  en_o, block_done, underflow, cur_out, ref_out, cur_s_ready, ref_s_ready);
      end
      tick();
      rst = 1'b1;
      tick();
      for (int i = 0; i < 64; i++) begin
         cur_s_valid = (i < 16);
         cur_s_data  = 32'h700 + 32'(i);
         ref_s_valid = 1'b1;
         ref_s_data  = {2{32'h7000 + 32'(i)}};
         tick();
      end
      idle();
      tick();
      tests++;
      if (en_o !== 1'b1) begin
         fails++;
         $display("FAIL mid_fresh_en: got %b want 1", en_o);
      end
      read_block(32'h700, 32'h7000, 1'b0, 32'h0, 32'h0, "fresh");
   endtask

   initial begin
      idle();
      test_reset();
      test_block();
      test_full();
      test_underflow();
      test_back_to_back();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
